// File: rtl/fp_add_sub_seq.sv
// Multi-cycle IEEE-754 style adder/subtractor: RNE rounding, special values, exception flags.
// Define FP_SUBNORMAL_EN for gradual underflow; without it subnormals flush to zero.
module fp_add_sub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         addsub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic [2:0]   dbg_state
);
  localparam int SW = MAN_W + 5;  // carry, hidden, fraction, guard, round, sticky
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]    a_q, a_d, b_q, b_d, sp_res_q, sp_res_d, result_q, result_d;
  logic [3:0]      sp_flg_q, sp_flg_d, flags_q, flags_d;
  logic            sp_q, sp_d, sign_q, sign_d, sub_q, sub_d, zero_q, zero_d, tiny_q, tiny_d;
  logic [XW-1:0]   exp_q, exp_d, exp_r;
  logic [SW-1:0]   sig_q, sig_d, sy_q, sy_d;
  logic [MAN_W+1:0] mant;
  int              lz;
`ifdef FP_SUBNORMAL_EN
  int              sh;
`endif

  logic [EXP_W-1:0] ea, eb, ex_a, ex_b, x_exp, y_exp, diff;
  logic [MAN_W-1:0] fa, fb, fr_a, fr_b;
  logic             hid_a, hid_b, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, swap;
  logic [SW-1:0]    x_sig, y_sig, y_sh;
  logic             inx, up;

  // Operand unpacking and alignment, evaluated from the captured operands.
  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign nan_a  = (&ea) && (|fa);
  assign nan_b  = (&eb) && (|fb);
  assign snan_a = nan_a && !fa[MAN_W-1];
  assign snan_b = nan_b && !fb[MAN_W-1];
  assign inf_a  = (&ea) && !(|fa);
  assign inf_b  = (&eb) && !(|fb);
  assign hid_a  = |ea;
  assign hid_b  = |eb;
`ifdef FP_SUBNORMAL_EN
  assign ex_a = hid_a ? ea : EXP_W'(1);
  assign ex_b = hid_b ? eb : EXP_W'(1);
  assign fr_a = fa;
  assign fr_b = fb;
`else
  assign ex_a = ea;
  assign ex_b = eb;
  assign fr_a = hid_a ? fa : {MAN_W{1'b0}};
  assign fr_b = hid_b ? fb : {MAN_W{1'b0}};
`endif
  assign swap  = {ex_b, hid_b, fr_b} > {ex_a, hid_a, fr_a};
  assign x_exp = swap ? ex_b : ex_a;
  assign y_exp = swap ? ex_a : ex_b;
  assign x_sig = swap ? {1'b0, hid_b, fr_b, 3'b000} : {1'b0, hid_a, fr_a, 3'b000};
  assign y_sig = swap ? {1'b0, hid_a, fr_a, 3'b000} : {1'b0, hid_b, fr_b, 3'b000};
  assign diff  = x_exp - y_exp;
  assign y_sh  = (int'(diff) > MAN_W + 3) ? {{(SW-1){1'b0}}, |y_sig}
               : ((y_sig >> diff) | {{(SW-1){1'b0}}, |(y_sig & ~({SW{1'b1}} << diff))});
  assign inx   = sig_q[2] | sig_q[1] | sig_q[0];
  assign up    = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready only in IDLE, out_valid held with stable data in DONE until out_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

  always_comb begin
    a_d = a_q; b_d = b_q; sp_d = sp_q; sp_res_d = sp_res_q; sp_flg_d = sp_flg_q;
    sign_d = sign_q; sub_d = sub_q; exp_d = exp_q; sig_d = sig_q; sy_d = sy_q;
    zero_d = zero_q; tiny_d = tiny_q; result_d = result_q; flags_d = flags_q;
    lz = 0; mant = '0; exp_r = '0;
`ifdef FP_SUBNORMAL_EN
    sh = 0;
`endif
    unique case (state_q)
      S_IDLE: if (in_valid && in_ready) begin
        a_d = a;
        b_d = {b[W-1] ^ addsub, b[W-2:0]};
      end
      S_ALIGN: begin
        sp_d = 1'b1;
        sp_flg_d = 4'b0000;
        sp_res_d = QNAN;
        if (nan_a || nan_b) sp_flg_d[3] = snan_a | snan_b;
        else if (inf_a && inf_b && (a_q[W-1] != b_q[W-1])) sp_flg_d[3] = 1'b1;
        else if (inf_a) sp_res_d = a_q;
        else if (inf_b) sp_res_d = b_q;
        else sp_d = 1'b0;
        sub_d  = a_q[W-1] ^ b_q[W-1];
        sign_d = swap ? b_q[W-1] : a_q[W-1];
        exp_d  = {2'b00, x_exp};
        sig_d  = x_sig;
        sy_d   = y_sh;
      end
      S_ADD: sig_d = sub_q ? (sig_q - sy_q) : (sig_q + sy_q);
      S_NORM: begin
        zero_d = 1'b0;
        tiny_d = 1'b0;
        for (int i = 0; i < SW - 1; i++) if (sig_q[i]) lz = SW - 2 - i;
        if (sig_q[SW-1]) begin
          sig_d = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + XW'(1);
        end else if (sig_q == '0) begin
          zero_d = 1'b1;
          sign_d = sign_q & ~sub_q;  // cancellation gives +0; (-0)+(-0) keeps -0
        end else begin
`ifdef FP_SUBNORMAL_EN
          sh     = (lz < int'(exp_q) - 1) ? lz : int'(exp_q) - 1;
          sig_d  = sig_q << sh;
          exp_d  = exp_q - XW'(sh);
          tiny_d = ~sig_d[SW-2];
`else
          if (lz >= int'(exp_q)) begin
            zero_d = 1'b1;
            tiny_d = 1'b1;
          end else begin
            sig_d = sig_q << lz;
            exp_d = exp_q - XW'(lz);
          end
`endif
        end
      end
      S_ROUND: begin
        mant  = {1'b0, sig_q[SW-2:3]} + {{(MAN_W+1){1'b0}}, up};
        exp_r = exp_q;
        if (mant[MAN_W+1]) begin
          mant  = mant >> 1;
          exp_r = exp_q + XW'(1);
        end
        if (sp_q) begin
          result_d = sp_res_q;
          flags_d  = sp_flg_q;
        end else if (zero_q) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          flags_d  = {2'b00, tiny_q, tiny_q};
        end else if (exp_r >= EXP_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d  = 4'b0101;
        end else begin
          // A cleared hidden bit means the value is subnormal, encoded with exponent 0.
          result_d = {sign_q, (mant[MAN_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), mant[MAN_W-1:0]};
          flags_d  = {2'b00, tiny_q & inx, inx};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0; b_q <= '0; sp_q <= 1'b0; sp_res_q <= '0; sp_flg_q <= '0;
      sign_q <= 1'b0; sub_q <= 1'b0; exp_q <= '0; sig_q <= '0; sy_q <= '0;
      zero_q <= 1'b0; tiny_q <= 1'b0; result_q <= '0; flags_q <= '0;
    end else begin
      a_q <= a_d; b_q <= b_d; sp_q <= sp_d; sp_res_q <= sp_res_d; sp_flg_q <= sp_flg_d;
      sign_q <= sign_d; sub_q <= sub_d; exp_q <= exp_d; sig_q <= sig_d; sy_q <= sy_d;
      zero_q <= zero_d; tiny_q <= tiny_d; result_q <= result_d; flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_add_sub_seq.sv
// Directed bench for fp_add_sub_seq (single precision) with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_fp_add_sub_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         addsub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [2:0]   dbg_state;

  logic [W+3:0] exp_q[$];
  vec_t         vecs[$];
  int           n_cmp = 0;
  int           n_err = 0;

  fp_add_sub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .addsub(addsub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops one expected entry per output handshake.
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (reset_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %h flags %b, expected no output", result, flags);
      end else begin
        e = exp_q.pop_front();
        if ({flags, result} !== e) begin
          n_err++;
          $display("FAIL result: got %h flags %b, expected %h flags %b",
                   result, flags, e[W-1:0], e[W+3:W]);
        end
      end
    end
  end

  // Driver: waits for in_ready, presents one operation for one accept edge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic op,
                       input logic [W-1:0] res, input logic [3:0] flg, input logic push);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    if (push) exp_q.push_back({flg, res});
    a = va; b = vb; addsub = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; addsub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, {31'b0, (t < 60)}, 32'd1);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
    vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
    vecs.push_back('{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001});
    vecs.push_back('{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 4'b0000});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000});
    vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000});
    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000});
    vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000});
`ifdef FP_SUBNORMAL_EN
    vecs.push_back('{32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 4'b0000});
    vecs.push_back('{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0001});
    vecs.push_back('{32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 4'b0000});
`else
    vecs.push_back('{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011});
    vecs.push_back('{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000});
    vecs.push_back('{32'h00400000, 32'h00400000, 1'b0, 32'h00000000, 4'b0000});
`endif

    // Reset
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; addsub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_flags", {28'b0, flags}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Latency and handshake timing on 1 + 2
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    check("busy_after_accept", {31'b0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_valid_before_e4", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("valid_after_e4", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    check("ready_after_handshake", {31'b0, in_ready}, 32'd1);
    check("valid_clear_after_handshake", {31'b0, out_valid}, 32'd0);
    wait_idle("idle_latency");

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f, 1'b1);
      wait_idle("idle_vector");
    end

    // Back-pressure: result held while out_ready is low; in_valid ignored meanwhile
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      check("stall_result", result, 32'h40400000);
      check("stall_flags", {28'b0, flags}, 32'h0);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("idle_stall");

    // Reset during ALIGN aborts the operation and clears the outputs immediately
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 4'b0000, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_flags", {28'b0, flags}, 32'h0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", {31'b0, in_ready}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("no_output_after_abort", {31'b0, out_valid}, 32'd0);
    issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1'b1);
    wait_idle("idle_after_abort");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
